mfp_adc_max10_arbiter: RTL and testbench

Packet-atomic arbiter that shares one Altera MAX10 ADC command/response stream between REQ_COUNT requesters, e.g. the AHB-managed ADC core and a DMA/sampling sequencer. It sits between the requesters' command outputs and the ADC IP. It grants one whole SOP..EOP command packet at a time, round-robin. It tags each granted packet with its owner ID in a small FIFO, then routes ADC responses back to the owning requester in order.

---
 rtl/mfp_adc_max10_arbiter_pkg.sv | 14 +
 rtl/mfp_adc_max10_arbiter_owner_fifo.sv | 52 +++++
 rtl/mfp_adc_max10_arbiter.sv | 153 +++++++++++++++
 tb/tb_mfp_adc_max10_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_adc_max10_arbiter_pkg.sv
// Shared types and widths for the MAX10 ADC stream arbiter.
// Owner IDs are 3 bits wide, which covers up to 8 requesters.
package mfp_adc_max10_arbiter_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int OWN_W  = 3;

endpackage

// File: rtl/mfp_adc_max10_arbiter_owner_fifo.sv
// Owner-ID FIFO: records which requester owns each outstanding command packet.
// A push is accepted while full only when a pop happens in the same cycle.
module mfp_adc_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_head  = r_mem[r_rd];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mfp_adc_max10_arbiter.sv
// Packet-atomic round-robin arbiter sharing one MAX10 ADC command/response stream.
// Define MFP_ADC_ARB_PRIO_EN to give requester 0 absolute priority at each grant.
module mfp_adc_max10_arbiter
    import mfp_adc_max10_arbiter_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    parameter int OWN_DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [REQ_COUNT-1:0]      REQ_C_Valid,
    input  logic [CH_W*REQ_COUNT-1:0] REQ_C_Channel,
    input  logic [REQ_COUNT-1:0]      REQ_C_SOP,
    input  logic [REQ_COUNT-1:0]      REQ_C_EOP,
    output logic [REQ_COUNT-1:0]      REQ_C_Ready,
    output logic [REQ_COUNT-1:0]      REQ_R_Valid,
    output logic [CH_W-1:0]           REQ_R_Channel,
    output logic [DATA_W-1:0]         REQ_R_Data,
    output logic                      REQ_R_SOP,
    output logic                      REQ_R_EOP,
    output logic                      ADC_C_Valid,
    output logic [CH_W-1:0]           ADC_C_Channel,
    output logic                      ADC_C_SOP,
    output logic                      ADC_C_EOP,
    input  logic                      ADC_C_Ready,
    input  logic                      ADC_R_Valid,
    input  logic [CH_W-1:0]           ADC_R_Channel,
    input  logic [DATA_W-1:0]         ADC_R_Data,
    input  logic                      ADC_R_SOP,
    input  logic                      ADC_R_EOP,
    output logic                      Busy,
    output logic                      Orphan
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OWN_W-1:0]     r_grant;
    logic [OWN_W-1:0]     w_grant_nxt;
    logic [OWN_W-1:0]     r_ptr;
    logic [OWN_W-1:0]     w_ptr_nxt;
    logic [OWN_W-1:0]     w_sel;
    logic [OWN_W-1:0]     w_head;
    logic [REQ_COUNT-1:0] w_elig;
    logic                 w_found;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_orphan;

    // Pick the first eligible requester at or after the RR pointer (wrapping).
    always_comb begin
        w_elig  = REQ_C_Valid & REQ_C_SOP;
        w_found = 1'b0;
        w_sel   = '0;
`ifdef MFP_ADC_ARB_PRIO_EN
        if (w_elig[0]) w_found = 1'b1;
`endif
        for (int k = 0; k < REQ_COUNT; k++) begin
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (!w_found && w_elig[i] &&
                    ((i - int'(r_ptr) + REQ_COUNT) % REQ_COUNT) == k) begin
                    w_found = 1'b1;
                    w_sel   = OWN_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !w_full) begin
                    w_grant_nxt = w_sel;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (ADC_C_Valid && ADC_C_Ready && ADC_C_EOP) begin
                    w_push      = 1'b1;
                    w_ptr_nxt   = (r_grant == OWN_W'(REQ_COUNT-1)) ? '0 : r_grant + 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_ptr    <= '0;
            r_orphan <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_ptr    <= w_ptr_nxt;
            if (ADC_R_Valid && w_empty) r_orphan <= 1'b1;
        end
    end

    // Command mux: the granted requester drives the ADC directly while busy.
    always_comb begin
        ADC_C_Valid   = 1'b0;
        ADC_C_Channel = '0;
        ADC_C_SOP     = 1'b0;
        ADC_C_EOP     = 1'b0;
        REQ_C_Ready   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (r_state == S_BUSY && r_grant == OWN_W'(i)) begin
                ADC_C_Valid    = REQ_C_Valid[i];
                ADC_C_Channel  = REQ_C_Channel[CH_W*i +: CH_W];
                ADC_C_SOP      = REQ_C_SOP[i];
                ADC_C_EOP      = REQ_C_EOP[i];
                REQ_C_Ready[i] = ADC_C_Ready;
            end
        end
    end

    always_comb begin
        REQ_R_Valid = '0;
        for (int i = 0; i < REQ_COUNT; i++)
            REQ_R_Valid[i] = ADC_R_Valid & ~w_empty & (w_head == OWN_W'(i));
    end

    assign w_pop         = ADC_R_Valid & ADC_R_EOP & ~w_empty;
    assign REQ_R_Channel = ADC_R_Channel;
    assign REQ_R_Data    = ADC_R_Data;
    assign REQ_R_SOP     = ADC_R_SOP;
    assign REQ_R_EOP     = ADC_R_EOP;
    assign Busy          = (r_state == S_BUSY) | ~w_empty;
    assign Orphan        = r_orphan;

    mfp_adc_owner_fifo #(
        .DEPTH (OWN_DEPTH),
        .W     (OWN_W)
    ) u_owner_fifo (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (r_grant),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_mfp_adc_max10_arbiter.sv
// Directed bench for mfp_adc_max10_arbiter with a queue-based reference model
// checked every cycle, plus literal expectations on grant and owner order.
module tb_mfp_adc_max10_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic            CLK;
    logic            RESETn;
    logic [N-1:0]    REQ_C_Valid;
    logic [5*N-1:0]  REQ_C_Channel;
    logic [N-1:0]    REQ_C_SOP;
    logic [N-1:0]    REQ_C_EOP;
    logic [N-1:0]    REQ_C_Ready;
    logic [N-1:0]    REQ_R_Valid;
    logic [4:0]      REQ_R_Channel;
    logic [11:0]     REQ_R_Data;
    logic            REQ_R_SOP;
    logic            REQ_R_EOP;
    logic            ADC_C_Valid;
    logic [4:0]      ADC_C_Channel;
    logic            ADC_C_SOP;
    logic            ADC_C_EOP;
    logic            ADC_C_Ready;
    logic            ADC_R_Valid;
    logic [4:0]      ADC_R_Channel;
    logic [11:0]     ADC_R_Data;
    logic            ADC_R_SOP;
    logic            ADC_R_EOP;
    logic            Busy;
    logic            Orphan;

    mfp_adc_max10_arbiter #(.REQ_COUNT(N), .OWN_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .REQ_C_Valid(REQ_C_Valid), .REQ_C_Channel(REQ_C_Channel),
        .REQ_C_SOP(REQ_C_SOP), .REQ_C_EOP(REQ_C_EOP), .REQ_C_Ready(REQ_C_Ready),
        .REQ_R_Valid(REQ_R_Valid), .REQ_R_Channel(REQ_R_Channel),
        .REQ_R_Data(REQ_R_Data), .REQ_R_SOP(REQ_R_SOP), .REQ_R_EOP(REQ_R_EOP),
        .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
        .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
        .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel),
        .ADC_R_Data(ADC_R_Data), .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP),
        .Busy(Busy), .Orphan(Orphan)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [4:0] chof(input int i);
        logic [5*N-1:0] t;
        t = REQ_C_Channel >> (5*i);
        return t[4:0];
    endfunction

    // Reference model: a busy flag, the granted owner, a rotating pointer and
    // a queue of outstanding owners, all updated from pre-edge inputs.
    bit m_busy;
    bit m_orphan;
    int m_grant;
    int m_ptr;
    int m_q[$];

    initial begin
        m_busy = 0; m_orphan = 0; m_grant = 0; m_ptr = 0;
        forever begin
            @(posedge CLK or negedge RESETn);
            if (!RESETn) begin
                m_busy = 0; m_orphan = 0; m_grant = 0; m_ptr = 0;
                m_q.delete();
            end else begin
                bit pop_now, push_now, was_full;
                logic [N-1:0] elig;
                pop_now  = ADC_R_Valid && ADC_R_EOP && (m_q.size() > 0);
                push_now = m_busy && bitof(REQ_C_Valid, m_grant) && ADC_C_Ready &&
                           bitof(REQ_C_EOP, m_grant);
                was_full = (m_q.size() >= DEPTH);
                if (ADC_R_Valid && m_q.size() == 0) m_orphan = 1;
                if (pop_now) void'(m_q.pop_front());
                if (m_busy) begin
                    if (push_now) begin
                        m_q.push_back(m_grant);
                        m_ptr  = (m_grant + 1) % N;
                        m_busy = 0;
                    end
                end else if (!was_full) begin
                    elig = REQ_C_Valid & REQ_C_SOP;
`ifdef MFP_ADC_ARB_PRIO_EN
                    if (elig[0]) begin
                        m_grant = 0;
                        m_busy  = 1;
                    end
`endif
                    for (int k = 0; k < N; k++) begin
                        if (!m_busy && bitof(elig, (m_ptr + k) % N)) begin
                            m_grant = (m_ptr + k) % N;
                            m_busy  = 1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus logs of observed order.
    int grant_log[$];
    int owner_log[$];

    initial forever begin
        logic [N-1:0] e_rdy, e_rv;
        @(negedge CLK);
        e_rdy = '0;
        e_rv  = '0;
        if (m_busy && ADC_C_Ready) e_rdy = N'(1) << m_grant;
        if (ADC_R_Valid && m_q.size() > 0) e_rv = N'(1) << m_q[0];
        chk("adc_c_valid", 32'(ADC_C_Valid), 32'(m_busy ? bitof(REQ_C_Valid, m_grant) : 1'b0));
        chk("adc_c_channel", 32'(ADC_C_Channel), 32'(m_busy ? chof(m_grant) : 5'd0));
        chk("adc_c_sop", 32'(ADC_C_SOP), 32'(m_busy ? bitof(REQ_C_SOP, m_grant) : 1'b0));
        chk("adc_c_eop", 32'(ADC_C_EOP), 32'(m_busy ? bitof(REQ_C_EOP, m_grant) : 1'b0));
        chk("req_c_ready", 32'(REQ_C_Ready), 32'(e_rdy));
        chk("req_r_valid", 32'(REQ_R_Valid), 32'(e_rv));
        chk("req_r_data", 32'(REQ_R_Data), 32'(ADC_R_Data));
        chk("req_r_channel", 32'(REQ_R_Channel), 32'(ADC_R_Channel));
        chk("busy", 32'(Busy), 32'(m_busy || m_q.size() > 0));
        chk("orphan", 32'(Orphan), 32'(m_orphan));
        for (int i = 0; i < N; i++) begin
            if (ADC_C_Valid && ADC_C_SOP && REQ_C_Ready[i]) grant_log.push_back(i);
            if (REQ_R_Valid[i] && REQ_R_EOP) owner_log.push_back(i);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i, input bit v, input bit sop, input bit eop, input logic [4:0] ch);
        REQ_C_Valid[i]       = v;
        REQ_C_SOP[i]         = sop;
        REQ_C_EOP[i]         = eop;
        REQ_C_Channel[5*i +: 5] = ch;
    endtask

    task automatic set_rsp(input bit v, input bit sop, input bit eop, input logic [11:0] d);
        ADC_R_Valid   = v;
        ADC_R_SOP     = sop;
        ADC_R_EOP     = eop;
        ADC_R_Data    = d;
        ADC_R_Channel = d[4:0];
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        REQ_C_Valid = '0; REQ_C_SOP = '0; REQ_C_EOP = '0; REQ_C_Channel = '0;
        ADC_C_Ready = 1'b0;
        set_rsp(0, 0, 0, 12'd0);
        repeat (2) tick();
        RESETn = 1'b1;
    endtask

    function automatic logic [31:0] pack_log(input int q[$], input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = (r << 4) | ((i < q.size()) ? 32'(q[i]) : 32'hF);
        return r;
    endfunction

    initial begin
        logic [31:0] exp_grants, exp_owners;
        n_cmp = 0;
        n_bad = 0;
`ifdef MFP_ADC_ARB_PRIO_EN
        exp_grants = 32'h0000;
        exp_owners = 32'h00000;
`else
        exp_grants = 32'h0101;
        exp_owners = 32'h01010;
`endif
        RESETn = 1'b0;
        REQ_C_Valid = '0; REQ_C_SOP = '0; REQ_C_EOP = '0; REQ_C_Channel = '0;
        ADC_C_Ready = 1'b0;
        set_rsp(0, 0, 0, 12'd0);
        repeat (2) tick();
        settle();
        chk("rst_adc_valid", 32'(ADC_C_Valid), 32'd0);
        chk("rst_ready", 32'(REQ_C_Ready), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_orphan", 32'(Orphan), 32'd0);
        chk("rst_channel", 32'(ADC_C_Channel), 32'd0);
        tick();
        RESETn = 1'b1;

        // 3-beat packet from requester 0, then a 3-beat reply
        ADC_C_Ready = 1'b1;
        set_req(0, 1, 1, 0, 5'd1);
        settle();
        chk("t1_no_valid_before_grant", 32'(ADC_C_Valid), 32'd0);
        tick();
        settle();
        chk("t1_valid_after_1cyc", 32'(ADC_C_Valid), 32'd1);
        chk("t1_beat1_ch", 32'(ADC_C_Channel), 32'd1);
        tick();
        set_req(0, 1, 0, 0, 5'd2);
        tick();
        set_req(0, 1, 0, 1, 5'd3);
        settle();
        chk("t1_beat3_eop", 32'(ADC_C_EOP), 32'd1);
        tick();
        set_req(0, 0, 0, 0, 5'd0);
        settle();
        chk("t1_idle_after_eop", 32'(ADC_C_Valid), 32'd0);
        chk("t1_busy_outstanding", 32'(Busy), 32'd1);
        set_rsp(1, 1, 0, 12'h111);
        settle();
        chk("t1_rsp_route", 32'(REQ_R_Valid), 32'b01);
        tick();
        set_rsp(1, 0, 0, 12'h222);
        tick();
        set_rsp(1, 0, 1, 12'h333);
        settle();
        chk("t1_rsp_route_eop", 32'(REQ_R_Valid), 32'b01);
        tick();
        set_rsp(0, 0, 0, 12'd0);
        settle();
        chk("t1_busy_clear", 32'(Busy), 32'd0);

        // Both requesters streaming single-beat packets until the FIFO fills
        do_reset();
        grant_log.delete();
        owner_log.delete();
        ADC_C_Ready = 1'b1;
        set_req(0, 1, 1, 1, 5'd4);
        set_req(1, 1, 1, 1, 5'd9);
        repeat (10) tick();
        settle();
        chk("t2_grant_order", pack_log(grant_log, 4), exp_grants);
        chk("t2_grant_count", 32'(grant_log.size()), 32'd4);
        chk("t2_full_no_grant", 32'(ADC_C_Valid), 32'd0);
        set_req(1, 0, 0, 0, 5'd0);
        set_rsp(1, 1, 1, 12'h0AA);
        settle();
        chk("t2_head_owner", 32'(REQ_R_Valid), 32'b01);
        tick();
        set_rsp(0, 0, 0, 12'd0);
        settle();
        chk("t2_no_grant_on_pop_edge", 32'(ADC_C_Valid), 32'd0);
        tick();
        settle();
        chk("t2_fifth_granted", 32'(ADC_C_Valid), 32'd1);
        chk("t2_fifth_ready", 32'(REQ_C_Ready), 32'b01);
        // push of this beat coincides with a response pop
        set_rsp(1, 1, 1, 12'h0BB);
        tick();
        set_req(0, 0, 0, 0, 5'd0);
        set_rsp(0, 0, 0, 12'd0);
        settle();
        chk("t2_busy_after_pushpop", 32'(Busy), 32'd1);
        repeat (3) begin
            set_rsp(1, 1, 1, 12'h0CC);
            tick();
        end
        set_rsp(0, 0, 0, 12'd0);
        settle();
        chk("t2_owner_order", pack_log(owner_log, 5), exp_owners);
        chk("t2_drained", 32'(Busy), 32'd0);

        // Stalled packet keeps its grant while another requester waits
        do_reset();
        set_req(1, 1, 1, 0, 5'd7);
        tick();
        set_req(0, 1, 1, 1, 5'd2);
        repeat (5) begin
            settle();
            chk("t3_stall_ready", 32'(REQ_C_Ready), 32'b00);
            chk("t3_stall_channel", 32'(ADC_C_Channel), 32'd7);
            tick();
        end
        ADC_C_Ready = 1'b1;
        settle();
        chk("t3_owner_ready", 32'(REQ_C_Ready), 32'b10);
        tick();
        set_req(1, 1, 0, 1, 5'd8);
        settle();
        chk("t3_still_owner", 32'(ADC_C_Channel), 32'd8);
        tick();
        set_req(1, 0, 0, 0, 5'd0);
        settle();
        chk("t3_gap_cycle", 32'(ADC_C_Valid), 32'd0);
        tick();
        settle();
        chk("t3_switch_ready", 32'(REQ_C_Ready), 32'b01);

        // Orphan response, then asynchronous reset mid-packet
        do_reset();
        set_rsp(1, 1, 1, 12'h5A5);
        settle();
        chk("t4_orphan_drop", 32'(REQ_R_Valid), 32'b00);
        tick();
        set_rsp(0, 0, 0, 12'd0);
        settle();
        chk("t4_orphan_set", 32'(Orphan), 32'd1);
        repeat (3) tick();
        chk("t4_orphan_sticky", 32'(Orphan), 32'd1);
        ADC_C_Ready = 1'b1;
        set_req(0, 1, 1, 0, 5'd3);
        tick();
        settle();
        chk("t4_midpkt_valid", 32'(ADC_C_Valid), 32'd1);
        RESETn = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(ADC_C_Valid), 32'd0);
        chk("t4_rst_ready", 32'(REQ_C_Ready), 32'd0);
        chk("t4_rst_orphan", 32'(Orphan), 32'd0);
        chk("t4_rst_busy", 32'(Busy), 32'd0);
        tick();
        set_req(0, 0, 0, 0, 5'd0);
        RESETn = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
